alu_core: RTL and testbench

- Datapath stage directly downstream of the ALU control decoder. It consumes the eight decoded AC control lines plus the AluClock/AluActive strobes.
- Computes an 8-bit result from operands A and B using the form: LHS-function + RHS-truth-table + carry-in. Result and flags are registered.
- The registered result is driven onto the bus only while AluActive is asserted.
- Flags are held in a flags register for the following instructions and can be restored from the bus.

---
 rtl/alu_core.sv | 111 +++++++++++
 tb/tb_alu_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// 8-bit ALU datapath stage: LHS function + RHS truth table + carry-in, registered result and flags.
// Optional overflow flag (V) is built only when ALU_OVERFLOW_FLAG_EN is defined.
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             AluClock,
    input  logic             AluActive,
    input  logic             AC0_RHS0,
    input  logic             AC1_RHS1,
    input  logic             AC2_RHS2,
    input  logic             AC3_RHS3,
    input  logic             AC4_LHS0,
    input  logic             AC5_LHS1,
    input  logic             AC6_CS0,
    input  logic             AC7_CS1,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             FlagsLoad,
    input  logic [3:0]       FlagsIn,
    output logic [WIDTH-1:0] AluResult,
    output logic [WIDTH-1:0] AluBusOut,
    output logic             FlagC,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagV
);

    // AluClock is a pure capture strobe with no backpressure: an operation presented
    // with AluClock=1 is committed on that rising edge; results appear one Clock later.
    logic [3:0]       rhs_tt;
    logic [1:0]       lhs_sel;
    logic [1:0]       cs_sel;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic             cin;
    logic [WIDTH:0]   sum;

    assign rhs_tt  = {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0};
    assign lhs_sel = {AC5_LHS1, AC4_LHS0};
    assign cs_sel  = {AC7_CS1, AC6_CS0};

    always_comb begin
        lhs = '0;
        rhs = '0;
        cin = 1'b0;
        case (lhs_sel)
            2'b00:   lhs = OperandA;
            2'b01:   lhs = '0;
            2'b10:   lhs = '1;
            default: lhs = ~OperandA;
        endcase
        // Each result bit looks up the truth table with {A[i],B[i]} as the index.
        for (int i = 0; i < WIDTH; i++) begin
            rhs[i] = rhs_tt[{OperandA[i], OperandB[i]}];
        end
        case (cs_sel)
            2'b00:   cin = 1'b0;
            2'b01:   cin = 1'b1;
            2'b10:   cin = FlagC;
            default: cin = ~FlagC;
        endcase
        sum = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, cin};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            AluResult <= '0;
            FlagC     <= 1'b0;
            FlagZ     <= 1'b0;
            FlagN     <= 1'b0;
        end else begin
            if (AluClock) begin
                AluResult <= sum[WIDTH-1:0];
            end
            // A flags restore takes precedence over the flags of a coincident capture.
            if (FlagsLoad) begin
                FlagC <= FlagsIn[0];
                FlagZ <= FlagsIn[1];
                FlagN <= FlagsIn[2];
            end else if (AluClock) begin
                FlagC <= sum[WIDTH];
                FlagZ <= (sum[WIDTH-1:0] == '0);
                FlagN <= sum[WIDTH-1];
            end
        end
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    logic v_next;
    assign v_next = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            FlagV <= 1'b0;
        end else if (FlagsLoad) begin
            FlagV <= FlagsIn[3];
        end else if (AluClock) begin
            FlagV <= v_next;
        end
    end
`else
    logic unused_flags_in_v;
    assign unused_flags_in_v = FlagsIn[3];
    assign FlagV = 1'b0;
`endif

    assign AluBusOut = AluActive ? AluResult : '0;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: driver pushes model predictions, monitor pops and compares each cycle.
module tb_alu_core;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       AluClock = 1'b0;
    logic       AluActive = 1'b0;
    logic       AC0_RHS0 = 1'b0, AC1_RHS1 = 1'b0, AC2_RHS2 = 1'b0, AC3_RHS3 = 1'b0;
    logic       AC4_LHS0 = 1'b0, AC5_LHS1 = 1'b0, AC6_CS0 = 1'b0, AC7_CS1 = 1'b0;
    logic [7:0] OperandA = 8'h00;
    logic [7:0] OperandB = 8'h00;
    logic       FlagsLoad = 1'b0;
    logic [3:0] FlagsIn = 4'h0;
    logic [7:0] AluResult;
    logic [7:0] AluBusOut;
    logic       FlagC, FlagZ, FlagN, FlagV;

    alu_core #(.WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .AluClock(AluClock), .AluActive(AluActive),
        .AC0_RHS0(AC0_RHS0), .AC1_RHS1(AC1_RHS1), .AC2_RHS2(AC2_RHS2), .AC3_RHS3(AC3_RHS3),
        .AC4_LHS0(AC4_LHS0), .AC5_LHS1(AC5_LHS1), .AC6_CS0(AC6_CS0), .AC7_CS1(AC7_CS1),
        .OperandA(OperandA), .OperandB(OperandB), .FlagsLoad(FlagsLoad), .FlagsIn(FlagsIn),
        .AluResult(AluResult), .AluBusOut(AluBusOut),
        .FlagC(FlagC), .FlagZ(FlagZ), .FlagN(FlagN), .FlagV(FlagV)
    );

    // Clock / watchdog
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: {bus[19:12], flags {V,N,Z,C} [11:8], result[7:0]}
    logic [19:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;

    // Architectural model state (what the registers should hold after each edge)
    logic [7:0] m_res = 8'h00;
    logic       m_c = 1'b0, m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ck, input logic act,
                         input logic [1:0] ls, input logic [3:0] rt, input logic [1:0] cs,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic fl, input logic [3:0] fin);
        logic [7:0] lv, rv;
        logic       cin;
        int         s, ss;
        @(negedge Clock);
        Reset = rst; AluClock = ck; AluActive = act;
        {AC5_LHS1, AC4_LHS0} = ls;
        {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0} = rt;
        {AC7_CS1, AC6_CS0} = cs;
        OperandA = a; OperandB = b; FlagsLoad = fl; FlagsIn = fin;

        case (ls)
            2'd0:    lv = a;
            2'd1:    lv = 8'h00;
            2'd2:    lv = 8'hFF;
            default: lv = 8'hFF - a;
        endcase
        for (int i = 0; i < 8; i++) rv[i] = rt[a[i] * 2 + b[i]];
        case (cs)
            2'd0:    cin = 1'b0;
            2'd1:    cin = 1'b1;
            2'd2:    cin = m_c;
            default: cin = !m_c;
        endcase
        s  = int'(lv) + int'(rv) + int'(cin);
        ss = int'($signed(lv)) + int'($signed(rv)) + int'(cin);

        if (rst) begin
            m_res = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        end else begin
            if (ck) m_res = 8'(s % 256);
            if (fl) begin
                m_c = fin[0]; m_z = fin[1]; m_n = fin[2];
`ifdef ALU_OVERFLOW_FLAG_EN
                m_v = fin[3];
`endif
            end else if (ck) begin
                m_c = (s > 255);
                m_z = ((s % 256) == 0);
                m_n = ((s % 256) >= 128);
`ifdef ALU_OVERFLOW_FLAG_EN
                m_v = (ss > 127) || (ss < -128);
`endif
            end
        end
        exp_q.push_back({(act ? m_res : 8'h00), m_v, m_n, m_z, m_c, m_res});
    endtask

    // Monitor: one prediction per edge, sampled just after the edge
    initial begin
        logic [19:0] e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", AluResult, e[7:0]);
                check("flags_vnzc", {4'h0, FlagV, FlagN, FlagZ, FlagC}, {4'h0, e[11:8]});
                check("bus", AluBusOut, e[19:12]);
            end
        end
    end

    // Stimulus
    initial begin
        drive(1, 1, 1, 2'b00, 4'b1010, 2'b00, 8'h12, 8'h34, 1, 4'hF);
        drive(1, 0, 0, 2'b00, 4'b1010, 2'b00, 8'h00, 8'h00, 0, 4'h0);
        // Build nonzero state, then reset with a pending capture and flags load
        drive(0, 1, 1, 2'b00, 4'b1010, 2'b00, 8'hFF, 8'h80, 0, 4'h0);
        drive(1, 1, 1, 2'b00, 4'b1010, 2'b01, 8'h33, 8'h44, 1, 4'hF);
        // 0x7F + 0x01: signed overflow, then drive bus
        drive(0, 1, 0, 2'b00, 4'b1010, 2'b00, 8'h7F, 8'h01, 0, 4'h0);
        drive(0, 0, 1, 2'b00, 4'b1010, 2'b00, 8'h7F, 8'h01, 0, 4'h0);
        // Subtract to zero, then ADC chain using carry flag
        drive(0, 1, 1, 2'b00, 4'b0101, 2'b01, 8'h05, 8'h05, 0, 4'h0);
        drive(0, 1, 1, 2'b00, 4'b1010, 2'b10, 8'hFF, 8'h00, 0, 4'h0);
        drive(0, 1, 1, 2'b00, 4'b1010, 2'b11, 8'h10, 8'h20, 0, 4'h0);
        // Logic ops through LHS=0
        drive(0, 1, 1, 2'b01, 4'b1000, 2'b00, 8'hF0, 8'h3C, 0, 4'h0);
        drive(0, 1, 1, 2'b01, 4'b0110, 2'b00, 8'hF0, 8'h3C, 0, 4'h0);
        drive(0, 1, 1, 2'b01, 4'b1110, 2'b00, 8'hF0, 8'h3C, 0, 4'h0);
        // Hold with new operands; bus released
        drive(0, 0, 1, 2'b11, 4'b1111, 2'b01, 8'hAA, 8'h55, 0, 4'h0);
        drive(0, 0, 0, 2'b10, 4'b0001, 2'b01, 8'h01, 8'hFE, 0, 4'h0);
        // Flags load coincident with capture
        drive(0, 1, 1, 2'b00, 4'b1010, 2'b00, 8'h01, 8'h01, 1, 4'b0101);
        drive(0, 1, 1, 2'b00, 4'b1010, 2'b10, 8'h01, 8'h01, 1, 4'b1010);
        // Wrap: 0xFF + 0x01
        drive(0, 1, 1, 2'b00, 4'b1010, 2'b00, 8'hFF, 8'h01, 0, 4'h0);
        drive(0, 1, 1, 2'b11, 4'b1010, 2'b01, 8'h80, 8'h01, 0, 4'h0);

        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
        end
        drive(0, 0, 1, 2'b00, 4'b0000, 2'b00, 8'h00, 8'h00, 0, 4'h0);

        @(posedge Clock);
        #2;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
